// File: rtl/arm_link_pkg.sv
// Shared types and defaults for the ARM-side link master.
// Optional build macro used by arm_link_master: ARM_LINK_SDI_SYNC_EN.
package arm_link_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_DATA_BITS    = 16;
    localparam int DEF_FRAME_PULSES = 17;
    localparam int NIB_W            = 4;

    // Nibble of the result byte the slave expects for a given phase.
    function automatic logic [NIB_W-1:0] sel_nib(input logic [7:0] b, input logic ph);
        return ph ? b[7:4] : b[3:0];
    endfunction

endpackage

// File: rtl/arm_link_timer.sv
// Half-period timer: down-counter restarted on each state entry, terminal
// count flags the last cycle of the current sclk half-period.
module arm_link_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tc
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 2;
    localparam logic [CW-1:0] LOAD_VAL = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Reload on state entry, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/arm_link_master.sv
// Master end of the 3-wire ARM/FPGA link. Generates sclk, shifts in the
// slave's word LSB first and returns result-byte nibbles on nib_out.
// Build option: define ARM_LINK_SDI_SYNC_EN to pass sdi through a 2-flop
// synchroniser before capture (needs CLK_DIV >= 4; otherwise >= 3).
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | sclk low, waiting for start
//   LOW   | sclk low half-period, nib_out stable for the coming rise
//   HIGH  | sclk high half-period, sdi captured in its last cycle
//   DONE  | one cycle, done pulse, rx_word already holds the frame word
module arm_link_master
    import arm_link_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int FRAME_PULSES = DEF_FRAME_PULSES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           tx_byte,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] rx_word,
    output logic                 sclk,
    input  logic                 sdi,
    output logic [NIB_W-1:0]     nib_out
);

    localparam int PCW = $clog2(FRAME_PULSES + 1);
    localparam logic [PCW-1:0] DATA_CNT  = PCW'(DATA_BITS);
    localparam logic [PCW-1:0] FRAME_CNT = PCW'(FRAME_PULSES);

`ifdef ARM_LINK_SDI_SYNC_EN
    if (CLK_DIV < 4) begin : g_div_check
        $error("arm_link_master: CLK_DIV must be >= 4 with the sdi synchroniser");
    end
`else
    if (CLK_DIV < 3) begin : g_div_check
        $error("arm_link_master: CLK_DIV must be >= 3");
    end
`endif

    state_t                 state_q;
    state_t                 state_nxt;
    logic                   tmr_load;
    logic                   tmr_tc;
    logic                   accept;
    logic                   last_high;
    logic [PCW-1:0]         pcnt_q;
    logic [PCW-1:0]         pcnt_inc;
    logic [DATA_BITS-1:0]   shreg_q;
    logic [DATA_BITS-1:0]   shreg_nxt;
    logic                   phase_q;
    logic [7:0]             byte_q;
    logic                   sdi_cap;

`ifdef ARM_LINK_SDI_SYNC_EN
    logic sdi_s1;
    logic sdi_s2;

    // Two-flop synchroniser; capture timing is unchanged, the extra latency
    // is absorbed by the longer minimum half-period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdi_s1 <= 1'b0;
            sdi_s2 <= 1'b0;
        end else begin
            sdi_s1 <= sdi;
            sdi_s2 <= sdi_s1;
        end
    end

    assign sdi_cap = sdi_s2;
`else
    assign sdi_cap = sdi;
`endif

    arm_link_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .tc   (tmr_tc)
    );

    assign pcnt_inc = pcnt_q + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state decode; the timer is reloaded on every state entry.
    always_comb begin
        state_nxt = state_q;
        tmr_load  = 1'b0;
        accept    = 1'b0;
        last_high = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    tmr_load  = 1'b1;
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (tmr_tc) begin
                    tmr_load  = 1'b1;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (tmr_tc) begin
                    last_high = 1'b1;
                    tmr_load  = 1'b1;
                    state_nxt = (pcnt_inc == FRAME_CNT) ? DONE : LOW;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shift register input: cleared on accept, one bit per data pulse.
    // The terminating pulse(s) beyond DATA_BITS leave it untouched.
    always_comb begin
        shreg_nxt = shreg_q;
        if (accept) begin
            shreg_nxt = '0;
        end else if (last_high && (pcnt_q < DATA_CNT)) begin
            shreg_nxt = {sdi_cap, shreg_q[DATA_BITS-1:1]};
        end
    end

    // Datapath: shift register, pulse count, nibble phase and result byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            pcnt_q  <= '0;
            phase_q <= 1'b0;
            byte_q  <= '0;
            nib_out <= '0;
        end else begin
            shreg_q <= shreg_nxt;
            if (accept) begin
                byte_q  <= tx_byte;
                pcnt_q  <= '0;
                nib_out <= sel_nib(tx_byte, phase_q);
            end else if (last_high) begin
                pcnt_q  <= pcnt_inc;
                phase_q <= ~phase_q;
                nib_out <= sel_nib(byte_q, ~phase_q);
            end
        end
    end

    // rx_word is loaded on DONE entry so it is valid in the same cycle as done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_word <= '0;
        end else if (last_high && (state_nxt == DONE)) begin
            rx_word <= shreg_nxt;
        end
    end

    // Registered link/handshake outputs, decoded from the next state so
    // they line up with the state register and never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            sclk <= (state_nxt == HIGH);
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_arm_link_master.sv
// Bench for arm_link_master: a behavioural slave on the link plus a
// timeline model of the frame, compared against the DUT every cycle.
module tb_arm_link_master;

    localparam int D         = 4;
    localparam int DB        = 16;
    localparam int FP        = 17;
    localparam int FRAME_LEN = 2 * D * FP;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  tx_byte = 8'h00;
    logic        sdi = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] rx_word;
    logic        sclk;
    logic [3:0]  nib_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;

    always #5 clk = ~clk;

    arm_link_master #(
        .CLK_DIV      (D),
        .DATA_BITS    (DB),
        .FRAME_PULSES (FP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_byte (tx_byte),
        .busy    (busy),
        .done    (done),
        .rx_word (rx_word),
        .sclk    (sclk),
        .sdi     (sdi),
        .nib_out (nib_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural slave ----------------
    logic [15:0] sl_word   = 16'h0000;
    logic        sl_dirty  = 1'b0;
    logic        sl_static = 1'b0;
    int          sl_k      = 0;
    logic        sl_ph     = 1'b0;
    logic [3:0]  sl_lo     = 4'h0;
    logic [3:0]  sl_hi     = 4'h0;
    logic [7:0]  sl_out    = 8'h00;
    logic        sclk_prev = 1'b0;
    logic        pend      = 1'b0;
    logic        pend_val  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sl_k = 0; sl_ph = 1'b0; pend = 1'b0; sclk_prev = 1'b0;
        end else begin
            #1;
            if (pend) begin sdi = pend_val; pend = 1'b0; end
            if (sclk && !sclk_prev) begin
                if (sl_ph) sl_hi = nib_out; else sl_lo = nib_out;
                sl_ph = ~sl_ph;
                if (sl_k < DB) begin
                    pend = 1'b1;
                    pend_val = sl_dirty ? sl_word[sl_k] : sl_static;
                end
                sl_k++;
                if (sl_k == FP) begin
                    sl_k = 0; sl_dirty = 1'b0; sl_out = {sl_hi, sl_lo};
                end
            end
            sclk_prev = sclk;
        end
    end

    // ---------------- frame timeline model ----------------
    logic        m_act  = 1'b0;
    int          m_n    = 0;
    logic [7:0]  m_tx   = 8'h00;
    logic        m_ph0  = 1'b0;
    logic        m_ph   = 1'b0;
    logic [15:0] m_word = 16'h0000;
    logic [15:0] m_rx   = 16'h0000;
    logic [3:0]  m_nib  = 4'h0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act = 1'b0; m_n = 0; m_ph = 1'b0; m_rx = '0; m_nib = '0;
        end else if (m_act) begin
            m_n++;
            if (m_n == FRAME_LEN) m_rx = m_word;
            if (m_n > FRAME_LEN) begin
                m_act = 1'b0;
                m_ph  = (FP % 2 == 1) ? ~m_ph0 : m_ph0;
                m_nib = m_ph ? m_tx[7:4] : m_tx[3:0];
            end
        end else if (start) begin
            m_act  = 1'b1;
            m_n    = 0;
            m_tx   = tx_byte;
            m_ph0  = m_ph;
            m_word = sl_dirty ? sl_word : {16{sl_static}};
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic       e_sclk, e_busy, e_done, ph;
        logic [3:0] e_nib;
        int         p;
        if (!rst) begin
            e_sclk = 0; e_busy = 0; e_done = 0; e_nib = '0;
        end else if (m_act) begin
            e_busy = 1'b1;
            e_done = (m_n == FRAME_LEN);
            e_sclk = (m_n < FRAME_LEN) && ((m_n % (2 * D)) >= D);
            p      = m_n / (2 * D);
            ph     = m_ph0 ^ p[0];
            e_nib  = ph ? m_tx[7:4] : m_tx[3:0];
        end else begin
            e_sclk = 0; e_busy = 0; e_done = 0; e_nib = m_nib;
        end
        chk("sclk", sclk, e_sclk);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("rx_word", rx_word, rst ? m_rx : 16'h0000);
        chk("nib_out", nib_out, e_nib);
        if (done) n_done++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic launch(input logic [7:0] tx);
        @(posedge clk); #1;
        start = 1'b1; tx_byte = tx;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (done || cyc > FRAME_LEN + 50) break;
            cyc++;
        end
        if (!done) $display("FAIL done_timeout: waited %0d cycles without done", cyc);
        chk("done_seen", done, 1'b1);
    endtask

    task automatic run_frame(input logic [7:0] tx, output int lat);
        launch(tx);
        wait_done(lat);
        @(posedge clk); #1;
    endtask

    task automatic load_slave(input logic [15:0] w, input logic dirty, input logic stat);
        sl_word = w; sl_dirty = dirty; sl_static = stat;
        if (!dirty) sdi = stat;
    endtask

    initial begin
        int          lat;
        int          c;
        int          d0;
        logic [15:0] w;
        logic [7:0]  tx;
        logic        dirty, stat;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rx", rx_word, 16'h0000);
        chk("rst_nib", nib_out, 4'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Loopback frame.
        load_slave(16'hA5C3, 1'b1, 1'b0);
        run_frame(8'h3C, lat);
        chk("latency", lat, 17 * 8);
        chk("rx_a5c3", rx_word, 16'hA5C3);
        chk("slave_out_3c", sl_out, 8'h3C);
        chk("slave_dirty_clr", sl_dirty, 1'b0);

        // Back-to-back frame starts on the high nibble.
        load_slave(16'h0001, 1'b1, 1'b0);
        launch(8'hE1);
        @(negedge clk);
        chk("hi_nib_first", nib_out, 4'hE);
        wait_done(lat);
        @(posedge clk); #1;
        chk("rx_0001", rx_word, 16'h0001);
        chk("slave_out_e1", sl_out, 8'hE1);

        // start held through the whole frame: exactly one frame.
        load_slave(16'h1234, 1'b1, 1'b0);
        d0 = n_done;
        @(posedge clk); #1;
        start = 1'b1; tx_byte = 8'h5A;
        wait_done(lat);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("hold_one_done", n_done - d0, 1);
        chk("hold_idle", busy, 1'b0);
        chk("hold_rx", rx_word, 16'h1234);

        // start coincident with done is ignored.
        load_slave(16'h8421, 1'b1, 1'b0);
        launch(8'h77);
        wait_done(lat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("coinc_ignored", busy, 1'b0);

        // Reset mid-frame at pulse 7.
        load_slave(16'hBEEF, 1'b1, 1'b0);
        launch(8'h96);
        c = 0;
        while (sl_k != 7 && c < 500) begin @(posedge clk); c++; end
        if (sl_k != 7) $display("FAIL pulse7_timeout: slave pulse count %0d", sl_k);
        chk("pulse7_reached", sl_k, 7);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_sclk", sclk, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rx", rx_word, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        load_slave(16'hC0DE, 1'b1, 1'b0);
        run_frame(8'h2B, lat);
        chk("post_rst_rx", rx_word, 16'hC0DE);
        chk("post_rst_out", sl_out, 8'h2B);

        // Slave not dirty, static high.
        load_slave(16'h0000, 1'b0, 1'b1);
        run_frame(8'h4D, lat);
        chk("not_dirty_rx", rx_word, 16'hFFFF);

        // Randomised frames.
        for (int i = 0; i < 20; i++) begin
            w     = 16'($urandom);
            tx    = 8'($urandom);
            dirty = ($urandom_range(0, 3) != 0);
            stat  = 1'($urandom);
            load_slave(w, dirty, stat);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            run_frame(tx, lat);
            chk("rand_latency", lat, FRAME_LEN);
            chk("rand_rx", rx_word, dirty ? w : {16{stat}});
            chk("rand_slave_out", sl_out, tx);
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
